// File: rtl/pcie_7x_mgt_pkg.sv
// Shared types for the PCIe 7-series MGT loopback endpoint: link states and
// per-lane symbol classes.
package pcie_7x_mgt_pkg;

    typedef enum logic [1:0] {
        DISABLED,
        DETECT,
        ACTIVE,
        FLUSH
    } state_t;

    typedef enum logic [1:0] {
        VALID,
        IDLE,
        ILLEGAL
    } sym_class_t;

    localparam int ERR_COUNT_W = 16;

    function automatic sym_class_t classify(input logic p, input logic n);
        case ({p, n})
            2'b00:   return IDLE;
            2'b11:   return ILLEGAL;
            default: return VALID;
        endcase
    endfunction

endpackage

// File: rtl/pcie_7x_mgt_lane_delay.sv
// One lane: symbol classification, idle qualification counter and the
// C_DELAY-stage loopback delay line whose last stage is the rx output register.
module pcie_7x_mgt_lane_delay
    import pcie_7x_mgt_pkg::*;
#(
    parameter int C_DELAY         = 4,
    parameter int C_DETECT_CYCLES = 8
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic       txp,
    input  logic       txn,
    input  logic       pass,
    output logic       rxp,
    output logic       rxn,
    output sym_class_t sym_class,
    output logic       idle
);

    localparam int CW = $clog2(C_DETECT_CYCLES + 1);

    logic [2*C_DELAY-1:0] line;
    logic [2*C_DELAY-1:0] shifted;
    logic [2*C_DELAY-1:0] keep;
    logic [CW-1:0]        idle_cnt;
    logic [CW-1:0]        idle_cnt_nxt;

    assign sym_class = classify(txp, txn);

    generate
        if (C_DELAY == 1) begin : g_single
            assign shifted = {txp, txn};
        end else begin : g_multi
            assign shifted = {line[2*C_DELAY-3:0], txp, txn};
        end
    endgenerate

    // The oldest stage is forced to electrical idle unless the link will be active.
    assign keep = pass ? {(2*C_DELAY){1'b1}} : ({(2*C_DELAY){1'b1}} >> 2);

    always_comb begin
        idle_cnt_nxt = '0;
        if (sym_class == IDLE) begin
            idle_cnt_nxt = idle_cnt;
            if (idle_cnt != CW'(C_DETECT_CYCLES))
                idle_cnt_nxt = idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            line     <= '0;
            idle_cnt <= '0;
            idle     <= 1'b0;
        end else begin
            line     <= shifted & keep;
            idle_cnt <= idle_cnt_nxt;
            idle     <= (idle_cnt_nxt == CW'(C_DETECT_CYCLES));
        end
    end

    assign rxp = line[2*C_DELAY-1];
    assign rxn = line[2*C_DELAY-2];

endmodule

// File: rtl/pcie_7x_mgt_loopback_endpoint.sv
// Loopback endpoint: qualifies all lanes, loops tx back to rx while ACTIVE,
// and tracks illegal symbols with sticky per-lane flags and a saturating count.
//   state    | meaning
//   DISABLED | endpoint off, rx at electrical idle
//   DETECT   | counting consecutive all-lanes-valid cycles
//   ACTIVE   | link up, rx = tx delayed C_DELAY cycles
//   FLUSH    | C_DELAY cycles of electrical idle before re-detect or shutdown
module pcie_7x_mgt_loopback_endpoint
    import pcie_7x_mgt_pkg::*;
#(
    parameter int C_LANES         = 1,
    parameter int C_DELAY         = 4,
    parameter int C_DETECT_CYCLES = 8
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   enable,
    input  logic                   clear,
    input  logic [C_LANES-1:0]     s_txp,
    input  logic [C_LANES-1:0]     s_txn,
    output logic [C_LANES-1:0]     s_rxp,
    output logic [C_LANES-1:0]     s_rxn,
    output logic                   link_up,
    output logic [C_LANES-1:0]     lane_idle,
    output logic [C_LANES-1:0]     lane_err,
    output logic [ERR_COUNT_W-1:0] err_count
);

    localparam int QW = $clog2(C_DETECT_CYCLES + 1);
    localparam int FW = $clog2(C_DELAY + 1);

    state_t        state;
    state_t        state_nxt;
    logic [QW-1:0] qual;
    logic [QW-1:0] qual_nxt;
    logic [FW-1:0] flush_cnt;
    logic          pass;

    sym_class_t         cls [C_LANES];
    logic [C_LANES-1:0] lane_ok;
    logic [C_LANES-1:0] lane_ill;

    for (genvar i = 0; i < C_LANES; i++) begin : g_lane
        pcie_7x_mgt_lane_delay #(
            .C_DELAY         (C_DELAY),
            .C_DETECT_CYCLES (C_DETECT_CYCLES)
        ) u_lane (
            .aclk      (aclk),
            .areset    (areset),
            .txp       (s_txp[i]),
            .txn       (s_txn[i]),
            .pass      (pass),
            .rxp       (s_rxp[i]),
            .rxn       (s_rxn[i]),
            .sym_class (cls[i]),
            .idle      (lane_idle[i])
        );
        assign lane_ok[i]  = (cls[i] == VALID);
        assign lane_ill[i] = (cls[i] == ILLEGAL);
    end

    always_comb begin
        state_nxt = state;
        qual_nxt  = '0;
        case (state)
            DISABLED: if (enable) state_nxt = DETECT;
            DETECT: begin
                if (!enable) begin
                    state_nxt = DISABLED;
                end else if (&lane_ok) begin
                    qual_nxt = qual + 1'b1;
                    if (qual_nxt == QW'(C_DETECT_CYCLES))
                        state_nxt = ACTIVE;
                end
            end
            ACTIVE: if (!enable || (|lane_idle)) state_nxt = FLUSH;
            FLUSH:  if (flush_cnt == '0) state_nxt = enable ? DETECT : DISABLED;
            default: state_nxt = DISABLED;
        endcase
    end

    assign pass = (state_nxt == ACTIVE);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= DISABLED;
            qual      <= '0;
            flush_cnt <= '0;
            link_up   <= 1'b0;
        end else begin
            state   <= state_nxt;
            qual    <= qual_nxt;
            link_up <= (state_nxt == ACTIVE);
            // Down-counter preloads outside FLUSH so it is ready on entry.
            if (state != FLUSH)
                flush_cnt <= FW'(C_DELAY - 1);
            else if (flush_cnt != '0)
                flush_cnt <= flush_cnt - 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            lane_err  <= '0;
            err_count <= '0;
        end else if (clear) begin
            lane_err  <= lane_ill;
            err_count <= (|lane_ill) ? ERR_COUNT_W'(1) : '0;
        end else begin
            lane_err <= lane_err | lane_ill;
            if ((|lane_ill) && (err_count != {ERR_COUNT_W{1'b1}}))
                err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pcie_7x_mgt_loopback_endpoint.sv
// Directed bench for the loopback endpoint with two lanes, 4-cycle delay and
// an 8-cycle detect window.
module tb_pcie_7x_mgt_loopback_endpoint;

    logic        aclk;
    logic        areset;
    logic        enable;
    logic        clear;
    logic [1:0]  s_txp;
    logic [1:0]  s_txn;
    logic [1:0]  s_rxp;
    logic [1:0]  s_rxn;
    logic        link_up;
    logic [1:0]  lane_idle;
    logic [1:0]  lane_err;
    logic [15:0] err_count;

    int checks = 0;
    int errors = 0;
    int ecnt   = 0;
    logic [1:0] hist_p [8];
    logic [1:0] hist_n [8];

    pcie_7x_mgt_loopback_endpoint #(
        .C_LANES         (2),
        .C_DELAY         (4),
        .C_DETECT_CYCLES (8)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .enable    (enable),
        .clear     (clear),
        .s_txp     (s_txp),
        .s_txn     (s_txn),
        .s_rxp     (s_rxp),
        .s_rxn     (s_rxn),
        .link_up   (link_up),
        .lane_idle (lane_idle),
        .lane_err  (lane_err),
        .err_count (err_count)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    function automatic logic [1:0] pat(input int j);
        return j[1:0];
    endfunction

    task automatic drive(input logic [1:0] p, input logic [1:0] n);
        s_txp = p;
        s_txn = n;
        hist_p[(ecnt + 1) & 7] = p;
        hist_n[(ecnt + 1) & 7] = n;
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
        ecnt++;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        enable = 1'b0;
        clear  = 1'b0;
        drive(2'b00, 2'b00);
        tick();
        tick();
        checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL reset link_up: got %b want 0", link_up); end
        checks++; if (s_rxp !== 2'b00) begin errors++; $display("FAIL reset s_rxp: got %b want 00", s_rxp); end
        checks++; if (s_rxn !== 2'b00) begin errors++; $display("FAIL reset s_rxn: got %b want 00", s_rxn); end
        checks++; if (lane_idle !== 2'b00) begin errors++; $display("FAIL reset lane_idle: got %b want 00", lane_idle); end
        checks++; if (lane_err !== 2'b00) begin errors++; $display("FAIL reset lane_err: got %b want 00", lane_err); end
        checks++; if (err_count !== 16'h0000) begin errors++; $display("FAIL reset err_count: got %h want 0000", err_count); end
        areset = 1'b0;
    endtask

    // Edge 1 enters DETECT; 5 valid, one idle on lane 1 at edge 7, then 8 valid.
    task automatic test_qual_restart();
        logic [1:0] p;
        logic       exp_link;
        for (int j = 1; j <= 16; j++) begin
            p = pat(j);
            enable = 1'b1;
            if (j == 7) drive({1'b0, p[0]}, {1'b0, ~p[0]});
            else        drive(p, ~p);
            tick();
            exp_link = (j >= 15);
            checks++;
            if (link_up !== exp_link) begin
                errors++;
                $display("FAIL qual_restart link_up step %0d: got %b want %b", j, link_up, exp_link);
            end
        end
    endtask

    // enable low for one cycle: 4 FLUSH cycles, back to DETECT, ACTIVE 8 valid cycles later.
    task automatic test_disable_flush();
        logic [1:0] p;
        logic       exp_link;
        logic [1:0] exp_rp;
        for (int j = 1; j <= 14; j++) begin
            p = pat(j);
            enable = (j != 1);
            drive(p, ~p);
            tick();
            exp_link = (j >= 13);
            exp_rp   = exp_link ? hist_p[(ecnt - 3) & 7] : 2'b00;
            checks++;
            if (link_up !== exp_link) begin
                errors++;
                $display("FAIL disable_flush link_up step %0d: got %b want %b", j, link_up, exp_link);
            end
            checks++;
            if (s_rxp !== exp_rp) begin
                errors++;
                $display("FAIL disable_flush s_rxp step %0d: got %b want %b", j, s_rxp, exp_rp);
            end
        end
    endtask

    // Lane 0 idle for 13 cycles: lane_idle at 8, FLUSH 9..12, DETECT at 13, ACTIVE at 21.
    task automatic test_idle_exit();
        logic [1:0] p;
        logic       exp_link;
        logic [1:0] exp_idle;
        logic [1:0] exp_rp;
        logic [1:0] exp_rn;
        for (int j = 1; j <= 22; j++) begin
            p = pat(j);
            enable = 1'b1;
            if (j <= 13) drive({p[1], 1'b0}, {~p[1], 1'b0});
            else         drive(p, ~p);
            tick();
            exp_link = (j <= 8) || (j >= 21);
            exp_idle = {1'b0, (j >= 8 && j <= 13)};
            exp_rp   = exp_link ? hist_p[(ecnt - 3) & 7] : 2'b00;
            exp_rn   = exp_link ? hist_n[(ecnt - 3) & 7] : 2'b00;
            checks++;
            if (link_up !== exp_link) begin
                errors++;
                $display("FAIL idle_exit link_up step %0d: got %b want %b", j, link_up, exp_link);
            end
            checks++;
            if (lane_idle !== exp_idle) begin
                errors++;
                $display("FAIL idle_exit lane_idle step %0d: got %b want %b", j, lane_idle, exp_idle);
            end
            checks++;
            if ({s_rxp, s_rxn} !== {exp_rp, exp_rn}) begin
                errors++;
                $display("FAIL idle_exit rx step %0d: got %b/%b want %b/%b", j, s_rxp, s_rxn, exp_rp, exp_rn);
            end
        end
    endtask

    task automatic test_errors();
        logic [1:0] tp   [9] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b11};
        logic [1:0] tn   [9] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11};
        logic       tclr [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [1:0] terr [9] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11};
        logic [15:0] tcnt[9] = '{16'd1, 16'd2, 16'd3, 16'd1, 16'd1, 16'd1, 16'd0, 16'd1, 16'd2};
        logic [1:0] exp_rp;
        for (int j = 0; j < 9; j++) begin
            enable = 1'b1;
            clear  = tclr[j];
            drive(tp[j], tn[j]);
            tick();
            clear  = 1'b0;
            exp_rp = hist_p[(ecnt - 3) & 7];
            checks++;
            if (lane_err !== terr[j]) begin
                errors++;
                $display("FAIL errors lane_err step %0d: got %b want %b", j, lane_err, terr[j]);
            end
            checks++;
            if (err_count !== tcnt[j]) begin
                errors++;
                $display("FAIL errors err_count step %0d: got %0d want %0d", j, err_count, tcnt[j]);
            end
            checks++;
            if (link_up !== 1'b1) begin
                errors++;
                $display("FAIL errors link_up step %0d: got %b want 1", j, link_up);
            end
            checks++;
            if (s_rxp !== exp_rp) begin
                errors++;
                $display("FAIL errors s_rxp step %0d: got %b want %b", j, s_rxp, exp_rp);
            end
        end
    endtask

    // err_count enters at 2; 65532 more illegal cycles give 0xFFFE, 70000 in total saturate.
    task automatic test_saturation();
        drive(2'b11, 2'b11);
        for (int k = 0; k < 65532; k++) tick();
        checks++;
        if (err_count !== 16'hFFFE) begin
            errors++;
            $display("FAIL saturation err_count pre: got %h want fffe", err_count);
        end
        for (int k = 0; k < 4468; k++) tick();
        checks++;
        if (err_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL saturation err_count: got %h want ffff", err_count);
        end
        checks++;
        if (link_up !== 1'b1) begin
            errors++;
            $display("FAIL saturation link_up: got %b want 1", link_up);
        end
        checks++;
        if (s_rxp !== 2'b11) begin
            errors++;
            $display("FAIL saturation s_rxp: got %b want 11", s_rxp);
        end
    endtask

    task automatic test_reset_mid_active();
        #2;
        areset = 1'b1;
        #1;
        checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL midreset link_up: got %b want 0", link_up); end
        checks++; if (s_rxp !== 2'b00) begin errors++; $display("FAIL midreset s_rxp: got %b want 00", s_rxp); end
        checks++; if (s_rxn !== 2'b00) begin errors++; $display("FAIL midreset s_rxn: got %b want 00", s_rxn); end
        checks++; if (lane_idle !== 2'b00) begin errors++; $display("FAIL midreset lane_idle: got %b want 00", lane_idle); end
        checks++; if (lane_err !== 2'b00) begin errors++; $display("FAIL midreset lane_err: got %b want 00", lane_err); end
        checks++; if (err_count !== 16'h0000) begin errors++; $display("FAIL midreset err_count: got %h want 0000", err_count); end
        enable = 1'b0;
        drive(2'b00, 2'b00);
        tick();
        tick();
        areset = 1'b0;
    endtask

    // Fresh start: DETECT at edge 1, ACTIVE at edge 9, rx = tx from 4 cycles earlier.
    task automatic test_bring_up();
        logic [1:0] p;
        logic       exp_link;
        logic [1:0] exp_rp;
        logic [1:0] exp_rn;
        for (int j = 1; j <= 12; j++) begin
            p = pat(j);
            enable = 1'b1;
            drive(p, ~p);
            tick();
            exp_link = (j >= 9);
            exp_rp   = exp_link ? hist_p[(ecnt - 3) & 7] : 2'b00;
            exp_rn   = exp_link ? hist_n[(ecnt - 3) & 7] : 2'b00;
            checks++;
            if (link_up !== exp_link) begin
                errors++;
                $display("FAIL bring_up link_up step %0d: got %b want %b", j, link_up, exp_link);
            end
            checks++;
            if (s_rxp !== exp_rp) begin
                errors++;
                $display("FAIL bring_up s_rxp step %0d: got %b want %b", j, s_rxp, exp_rp);
            end
            checks++;
            if (s_rxn !== exp_rn) begin
                errors++;
                $display("FAIL bring_up s_rxn step %0d: got %b want %b", j, s_rxn, exp_rn);
            end
        end
        checks++;
        if ({lane_err, err_count} !== 18'd0) begin
            errors++;
            $display("FAIL bring_up errors: got %b/%h want 00/0000", lane_err, err_count);
        end
    endtask

    initial begin
        test_reset();
        test_qual_restart();
        test_disable_flush();
        test_idle_exit();
        test_errors();
        test_saturation();
        test_reset_mid_active();
        test_bring_up();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
